mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
- MEM stage of the 5-stage ARM pipeline. Takes the EX/MEM payload, runs LDR/STR as 32-bit words over a 16-bit external SRAM in two half-word accesses, and stalls the pipeline while an access is in flight.
- Holds the MEM/WB pipeline register. Its wb_en/wb_dest/wb_value outputs drive writeBackEn/Dest_wb/Result_wb of the register file.
- The register file writes on negedge; this block updates on posedge.

Parameters:
ADDR_BASE, 1024, byte address mapped to SRAM word 0.
HALF_CYCLES, 3, cycles per half-word SRAM access (legal range 1..15).

Ports:
clk  in  1  pipeline clock, posedge.
rst  in  1  reset: asynchronous, active-high.
mem_r_en  in  1  LDR in MEM stage.
mem_w_en  in  1  STR in MEM stage.
wb_en_in  in  1  instruction writes a register.
dest_in  in  4  destination register index.
alu_res  in  32  ALU result / byte address.
st_val  in  32  store data.
freeze  out  1  stall for all upstream stage registers and PC.
sram_addr  out  18  SRAM half-word address.
sram_dq_o  out  16  SRAM write data.
sram_dq_oe  out  1  tristate enable for sram_dq_o.
sram_dq_i  in  16  SRAM read data.
sram_we_n  out  1  SRAM write strobe, active-low.
wb_en  out  1  MEM/WB: write-back enable.
wb_dest  out  4  MEM/WB: destination register.
wb_value  out  32  MEM/WB: load data if mem_r_en, else alu_res.

Behaviour:
- Reset (async, any state) forces the following; rst overrides the FSM mid-access and the access is abandoned:
  - state=IDLE, cnt=0, rdata=0.
  - wb_en=0, wb_dest=0, wb_value=0.
  - freeze=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
- req = mem_r_en | mem_w_en. If both are high, the access is treated as a write. mem_r_en then has no effect: wb_value=alu_res.
- Address: off = alu_res - ADDR_BASE (32-bit wrap).
  - sram_addr = {off[18:2], half}; half=0 in LO, 1 in HI.
  - off[1:0] is ignored (word-aligned only).
- FSM states IDLE, LO, HI, DONE:
  - IDLE: if req, go to LO with cnt=0; else stay.
  - LO: cnt increments each cycle. When cnt==HALF_CYCLES-1: rdata[15:0]<=sram_dq_i (reads only), cnt<=0, go to HI.
  - HI: same as LO but captures rdata[31:16], then goes to DONE.
  - DONE: unconditionally go to IDLE.
- freeze = req & (state!=DONE), combinational.
  - A memory instruction sees exactly 1+2*HALF_CYCLES frozen cycles, then one unfrozen DONE cycle.
  - Non-memory instructions never freeze.
- Write drive in LO/HI only: sram_we_n=0, sram_dq_oe=1, sram_dq_o = st_val[15:0] (LO) / st_val[31:16] (HI).
- Read drive: sram_we_n=1, sram_dq_oe=0.
- In IDLE/DONE: sram_we_n=1, sram_dq_oe=0, addr still driven.
- MEM/WB register loads on posedge when freeze==0: wb_en<=wb_en_in, wb_dest<=dest_in, wb_value<=mem_r_en?rdata_final:alu_res.
  - For a read in DONE, rdata_final = {rdata[31:16], rdata[15:0]}; both halves are already captured.
  - When freeze==1 the register holds.
  - Store with wb_en_in=1 is passed through unchanged (not filtered).
- Back-to-back memory instructions: DONE->IDLE->LO; the second instruction freezes from its first cycle.
- req dropping mid-access is not legal (pipeline frozen). If it happens anyway, the FSM completes the access and freeze follows req.

Optional Feature:
- Macro MEM_STALL_COUNTER_EN.
- Defined: adds output stall_cnt[31:0]. Reset 0; increments on every cycle freeze==1; saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package mem_stage_pkg: state enum (IDLE/LO/HI/DONE), SRAM_AW=18, SRAM_DW=16, REG_IDX_W=4, WORD_W=32.
- Sub-module mem_wb_reg: the freeze-gated MEM/WB register with async reset, 1+4+32 bits.
- FSM and SRAM drive stay in the top module.

Test Plan:
1. Reset mid-access: assert rst in HI of a write -> within the same cycle sram_we_n=1, sram_dq_oe=0, freeze=0, wb_*=0; after release, state IDLE.
2. Non-memory op: wb_en_in=1, dest_in=5, alu_res=0x1234 -> freeze stays 0; next posedge wb_en=1, wb_dest=5, wb_value=0x1234.
3. STR: alu_res=1024+8, st_val=0xDEADBEEF, HALF_CYCLES=3 -> freeze high 7 cycles.
   - sram_addr=4 with dq_o=0xBEEF for 3 cycles, then addr=5 with dq_o=0xDEAD for 3 cycles; we_n low for all 6.
4. LDR: alu_res=1024+12, model returns 0x5678 at addr 6 and 0x1234 at addr 7 -> after DONE, wb_value=0x12345678, wb_dest=dest_in, we_n stays high.
5. Back-to-back LDR then STR: freeze pattern 7 high, 1 low, 7 high; the MEM/WB register updates only on the two low cycles plus the following non-memory cycle.
6. MEM_STALL_COUNTER_EN defined, two accesses, HALF_CYCLES=2 -> stall_cnt=10; a both-enables-high request -> SRAM write occurs and wb_value=alu_res.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM stage: access FSM states and the MEM/WB payload.
package mem_stage_pkg;

  localparam int SRAM_AW   = 18;
  localparam int SRAM_DW   = 16;
  localparam int REG_IDX_W = 4;
  localparam int WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic                 en;
    logic [REG_IDX_W-1:0] dest;
    logic [WORD_W-1:0]    value;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads on posedge whenever load_i is high, holds otherwise.
// One-cycle latency; the caller stalls it by dropping load_i while the pipeline is frozen.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 wb_en_i,
  input  logic [REG_IDX_W-1:0] wb_dest_i,
  input  logic [WORD_W-1:0]    wb_value_i,
  output logic                 wb_en_o,
  output logic [REG_IDX_W-1:0] wb_dest_o,
  output logic [WORD_W-1:0]    wb_value_o
);

  mem_wb_t wb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else if (load_i) begin
      wb_q <= '{en: wb_en_i, dest: wb_dest_i, value: wb_value_i};
    end
  end

  assign wb_en_o    = wb_q.en;
  assign wb_dest_o  = wb_q.dest;
  assign wb_value_o = wb_q.value;

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: 32-bit LDR/STR as two half-word accesses on a 16-bit SRAM, freezing upstream meanwhile.
// Access costs 1+2*HALF_CYCLES frozen cycles; MEM_STALL_COUNTER_EN adds a saturating stall_cnt output.
module mem_stage_sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BASE   = 1024,
  parameter int HALF_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic                 wb_en_in,
  input  logic [REG_IDX_W-1:0] dest_in,
  input  logic [WORD_W-1:0]    alu_res,
  input  logic [WORD_W-1:0]    st_val,
  output logic                 freeze,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]   sram_dq_o,
  output logic                 sram_dq_oe,
  input  logic [SRAM_DW-1:0]   sram_dq_i,
  output logic                 sram_we_n,
  output logic                 wb_en,
  output logic [REG_IDX_W-1:0] wb_dest,
  output logic [WORD_W-1:0]    wb_value
`ifdef MEM_STALL_COUNTER_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam logic [3:0] CNT_LAST = 4'(HALF_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                req, is_wr, is_rd;
  logic                half, drive;
  logic [SRAM_AW-2:0]  word_off;

  assign req   = mem_r_en | mem_w_en;
  assign is_wr = mem_w_en;
  // A request with both enables set is a write; the read side is ignored.
  assign is_rd = mem_r_en & ~mem_w_en;

  assign word_off = 17'((alu_res - 32'(ADDR_BASE)) >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    half    = 1'b0;
    drive   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_d   = '0;
        end
      end
      LO: begin
        drive = is_wr;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = HI;
          if (is_rd) rdata_d[15:0] = sram_dq_i;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        half  = 1'b1;
        drive = is_wr;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          if (is_rd) rdata_d[31:16] = sram_dq_i;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset must quiet the bus and release the pipeline in the same cycle it is asserted.
  assign freeze     = req & (state_q != DONE) & ~rst;
  assign sram_addr  = rst ? '0 : {word_off, half};
  assign sram_dq_oe = drive & ~rst;
  assign sram_we_n  = ~(drive & ~rst);
  assign sram_dq_o  = (drive & ~rst) ? (half ? st_val[31:16] : st_val[15:0]) : '0;

  mem_wb_reg u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (~freeze),
    .wb_en_i    (wb_en_in),
    .wb_dest_i  (dest_in),
    .wb_value_i (is_rd ? rdata_q : alu_res),
    .wb_en_o    (wb_en),
    .wb_dest_o  (wb_dest),
    .wb_value_o (wb_value)
  );

`ifdef MEM_STALL_COUNTER_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (freeze && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl: driver queues per-cycle and MEM/WB expectations, monitor checks at negedge.
module tb_mem_stage_sram_ctrl;

  localparam int HC = 3;

  typedef struct {
    logic [1:0]  mode;   // 0: idle/done, 1: LO/HI access, 2: in reset
    logic        frz;
    logic        we_n;
    logic        oe;
    logic [17:0] addr;
    logic [15:0] dq;
    logic        acc;    // MEM/WB loads at the following posedge
  } cyc_t;

  typedef struct {
    logic        en;
    logic [3:0]  dest;
    logic [31:0] val;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en, wb_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res, st_val;
  logic        freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
`ifdef MEM_STALL_COUNTER_EN
  logic [31:0] stall_cnt;
`endif

  cyc_t cq[$];
  wb_t  wbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_stall = 0;
  logic wb_pend = 1'b0;
  logic [15:0] smem [16];

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.ADDR_BASE(1024), .HALF_CYCLES(HC)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .wb_en_in   (wb_en_in),
    .dest_in    (dest_in),
    .alu_res    (alu_res),
    .st_val     (st_val),
    .freeze     (freeze),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_we_n  (sram_we_n),
    .wb_en      (wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value)
`ifdef MEM_STALL_COUNTER_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // Small SRAM model: asynchronous read, write on posedge while we_n is low.
  assign sram_dq_i = smem[sram_addr[3:0]];
  always @(posedge clk) begin
    if (!rst && !sram_we_n) smem[sram_addr[3:0]] <= sram_dq_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    cyc_t e;
    wb_t  w;
    if (wb_pend) begin
      wb_pend = 1'b0;
      if (wbq.size() > 0) begin
        w = wbq.pop_front();
        chk("wb_en", {31'd0, wb_en}, {31'd0, w.en});
        chk("wb_dest", {28'd0, wb_dest}, {28'd0, w.dest});
        chk("wb_value", wb_value, w.val);
      end
    end
    if (cq.size() > 0) begin
      e = cq.pop_front();
      chk("freeze", {31'd0, freeze}, {31'd0, e.frz});
      chk("we_n", {31'd0, sram_we_n}, {31'd0, e.we_n});
      chk("dq_oe", {31'd0, sram_dq_oe}, {31'd0, e.oe});
      if (e.mode != 2'd0) chk("sram_addr", {14'd0, sram_addr}, {14'd0, e.addr});
      if (e.mode == 2'd2 || e.oe) chk("dq_o", {16'd0, sram_dq_o}, {16'd0, e.dq});
      if (e.mode == 2'd2) begin
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_wb_dest", {28'd0, wb_dest}, 32'd0);
        chk("rst_wb_value", wb_value, 32'd0);
      end
      wb_pend = e.acc;
    end
  end

  function automatic cyc_t mk_cyc(input int i, input logic w, input logic [16:0] word,
                                  input logic [31:0] st);
    cyc_t e;
    logic h;
    h      = (i > HC);
    e.frz  = 1'b1;
    e.acc  = 1'b0;
    if (i == 0) begin
      e.mode = 2'd0; e.we_n = 1'b1; e.oe = 1'b0; e.addr = '0; e.dq = '0;
    end else begin
      e.mode = 2'd1; e.we_n = ~w; e.oe = w; e.addr = {word, h};
      e.dq   = h ? st[31:16] : st[15:0];
    end
    return e;
  endfunction

  function automatic cyc_t mk_rst();
    cyc_t e;
    e.mode = 2'd2; e.frz = 1'b0; e.we_n = 1'b1; e.oe = 1'b0;
    e.addr = '0; e.dq = '0; e.acc = 1'b0;
    return e;
  endfunction

  // Called at posedge+1; holds the instruction until it leaves the stage.
  task automatic issue(input logic r, input logic w, input logic we_in, input logic [3:0] dest,
                       input logic [31:0] alu, input logic [31:0] st, input logic [16:0] word,
                       input logic [31:0] exp_val);
    cyc_t e;
    wb_t  x;
    int   n;
    mem_r_en = r; mem_w_en = w; wb_en_in = we_in; dest_in = dest; alu_res = alu; st_val = st;
    n = (r | w) ? 1 + 2 * HC : 0;
    for (int i = 0; i < n; i++) cq.push_back(mk_cyc(i, w, word, st));
    exp_stall += n;
    e.mode = 2'd0; e.frz = 1'b0; e.we_n = 1'b1; e.oe = 1'b0; e.addr = '0; e.dq = '0; e.acc = 1'b1;
    cq.push_back(e);
    x.en = we_in; x.dest = dest; x.val = exp_val;
    wbq.push_back(x);
    repeat (n + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) smem[i] = 16'h0;
    smem[6] = 16'h5678;
    smem[7] = 16'h1234;
    rst = 1'b1;
    mem_r_en = 0; mem_w_en = 0; wb_en_in = 0; dest_in = 0; alu_res = 0; st_val = 0;
    @(posedge clk); #1; cq.push_back(mk_rst());
    @(posedge clk); #1; cq.push_back(mk_rst());
    @(posedge clk); #1; rst = 1'b0;

    issue(0, 0, 1, 4'd5, 32'h1234,        32'h0,         17'd0, 32'h1234);
    issue(0, 1, 0, 4'd0, 32'd1032,        32'hDEADBEEF,  17'd2, 32'd1032);
    issue(1, 0, 1, 4'd3, 32'd1036,        32'h0,         17'd3, 32'h12345678);
    issue(1, 0, 1, 4'd7, 32'd1032,        32'h0,         17'd2, 32'hDEADBEEF);
    issue(0, 1, 1, 4'd9, 32'd1040,        32'hCAFEF00D,  17'd4, 32'd1040);
    issue(0, 0, 1, 4'd2, 32'h55,          32'h0,         17'd0, 32'h55);
    issue(1, 0, 1, 4'd4, 32'd1040,        32'h0,         17'd4, 32'hCAFEF00D);
    issue(1, 1, 1, 4'd6, 32'd1048,        32'h11112222,  17'd6, 32'd1048);
    issue(1, 0, 1, 4'd8, 32'd1048,        32'h0,         17'd6, 32'h11112222);

    // Write abandoned by reset in its first HI cycle's successor
    mem_r_en = 0; mem_w_en = 1; wb_en_in = 1; dest_in = 4'd11; alu_res = 32'd1056; st_val = 32'hA5A55A5A;
    for (int i = 0; i < 1 + HC + 1; i++) cq.push_back(mk_cyc(i, 1'b1, 17'd8, 32'hA5A55A5A));
    repeat (1 + HC + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_stall = 0;
    cq.push_back(mk_rst());
    @(posedge clk); #1; cq.push_back(mk_rst());
    @(posedge clk); #1; rst = 1'b0;

    issue(0, 0, 1, 4'd1,  32'h99,   32'h0, 17'd0, 32'h99);
    issue(1, 0, 1, 4'd10, 32'd1036, 32'h0, 17'd3, 32'h12345678);
    issue(0, 0, 0, 4'd0,  32'h0,    32'h0, 17'd0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("cycle_queue_drained", cq.size(), 32'd0);
    chk("wb_queue_drained", wbq.size(), 32'd0);
`ifdef MEM_STALL_COUNTER_EN
    chk("stall_cnt", stall_cnt, exp_stall);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
